// File: rtl/pipe_pkg.sv
// Shared pipeline types for the forwarding scoreboard.
// Entry record, forward-select and ready-stage encodings.
package pipe_pkg;

    // Widest register index and ready field an entry can hold.
    localparam int MAX_AW    = 8;
    localparam int MAX_SEL_W = 4;

    // Select value meaning "read the register file".
    localparam int SEL_RF = 0;

    // Stage at which a result first becomes forwardable.
    localparam int READY_ALU  = 0;
    localparam int READY_LOAD = 1;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic [MAX_AW-1:0]    rd;
        logic [MAX_SEL_W-1:0] ready;
    } entry_t;

endpackage

// File: rtl/fwd_select.sv
// Priority match of one source register over the in-flight entries.
// The youngest matching producer decides the select or a not-ready flag.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  entry_t [DEPTH-1:0] i_entries,
    input  logic [REG_AW-1:0]  i_src,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_not_ready
);

    // Scan oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        o_sel       = SEL_W'(SEL_RF);
        o_not_ready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_entries[k].valid && i_entries[k].regwrite &&
                (i_entries[k].rd != '0) &&
                (i_entries[k].rd == MAX_AW'(i_src))) begin
                if (i_entries[k].ready <= MAX_SEL_W'(k)) begin
                    o_sel       = SEL_W'(k + 1);
                    o_not_ready = 1'b0;
                end else begin
                    o_sel       = SEL_W'(SEL_RF);
                    o_not_ready = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight producers and chooses operand forwarding or a stall.
// Entry 0 is the youngest (EX); the oldest entry retires every cycle.
module forward_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              issue_valid_i,
    input  logic              issue_regwrite_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [SEL_W-1:0]  issue_ready_i,
    input  logic [REG_AW-1:0] src_a_i,
    input  logic [REG_AW-1:0] src_b_i,
    input  logic              flush_i,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic              stall_o,
    output logic [15:0]       stall_cnt_o
);

    entry_t [DEPTH-1:0] r_entries;
    logic [15:0]        r_stall_cnt;

    entry_t             w_new;
    logic [SEL_W-1:0]   w_sel_a;
    logic [SEL_W-1:0]   w_sel_b;
    logic               w_nr_a;
    logic               w_nr_b;
    logic               w_stall;
    logic               w_load;

    fwd_select #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_sel_a (
        .i_entries   (r_entries),
        .i_src       (src_a_i),
        .o_sel       (w_sel_a),
        .o_not_ready (w_nr_a)
    );

    fwd_select #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) u_sel_b (
        .i_entries   (r_entries),
        .i_src       (src_b_i),
        .o_sel       (w_sel_b),
        .o_not_ready (w_nr_b)
    );

    // Stall on a not-ready producer; a flushed slot never stalls.
    always_comb begin
        w_stall = issue_valid_i && !flush_i && (w_nr_a || w_nr_b);
        w_load  = issue_valid_i && !w_stall && !flush_i;

        w_new          = '0;
        w_new.valid    = w_load;
        w_new.regwrite = issue_regwrite_i;
        w_new.rd       = MAX_AW'(issue_rd_i);
        w_new.ready    = MAX_SEL_W'(issue_ready_i);

        stall_o = w_stall;
        fwd_a_o = w_stall ? SEL_W'(SEL_RF) : w_sel_a;
        fwd_b_o = w_stall ? SEL_W'(SEL_RF) : w_sel_b;
    end

    // Shift the producer pipeline; entry 0 takes the issue or a bubble.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_entries <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_entries[k] <= r_entries[k-1];
            end
            r_entries[0] <= w_new;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning the register-index width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight producer stages (EX/MEM/WB...); range 2..8.
REQ-003 SHALL have localparam SEL_W = clog2(DEPTH+1), meaning the forward-select width.
REQ-004 SHALL have port clk_i  input  1  -- the single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  -- reset, synchronous and active-low.
REQ-006 SHALL have port issue_valid_i  input  1  -- the decode-stage instruction advances into EX this cycle unless stall_o is high.
REQ-007 SHALL have port issue_regwrite_i  input  1  -- the issuing instruction writes a register.
REQ-008 SHALL have port issue_rd_i  input  REG_AW  -- the issuing destination.
REQ-009 SHALL have port issue_ready_i  input  SEL_W  -- the tracked stage index (0..DEPTH-1) at which the result first becomes forwardable (ALU=0, load=1).
REQ-010 SHALL have ports src_a_i and src_b_i  input  REG_AW  -- the decode-stage source registers.
REQ-011 SHALL have port flush_i  input  1  -- kills the decode instruction and entry 0.
REQ-012 SHALL have ports fwd_a_o and fwd_b_o  output  SEL_W  -- 0 = register file; k+1 = forward from entry k.
REQ-013 SHALL have port stall_o  output  1  -- hold decode and insert a bubble.
REQ-014 SHALL have port stall_cnt_o  output  16  -- the saturating count of stall cycles.

Function
REQ-015 SHALL hold DEPTH entries {valid, regwrite, rd, ready}, where entry 0 is the youngest (EX).
REQ-016 SHALL shift on every clock: entry[k] <= entry[k-1] for k>=1; entry DEPTH-1 retires.
REQ-017 SHALL load entry[0] with the issue fields when issue_valid_i && !stall_o && !flush_i, else with a bubble (valid=0).
REQ-018 SHALL treat entry k as matching source s when valid && regwrite && rd!=0 && rd==s.
REQ-019 SHALL select, per source, the lowest-index (youngest) matching entry; older matches are ignored.
REQ-020 SHALL drive fwd_x_o = k+1 when the selected entry has ready<=k, and 0 when no entry matches.
REQ-021 SHALL assert stall_o combinationally when either source's selected entry has ready>k and issue_valid_i=1 and flush_i=0.
REQ-022 SHALL drive fwd_x_o to 0 while stall_o=1.
REQ-023 SHALL keep src_a and src_b independent; the same register on both SHALL give identical selects.
REQ-024 SHALL never stall or forward for source 0.
REQ-025 SHALL, when flush_i=1, set stall_o=0 and force the entry-0 load to a bubble; older entries still shift.
REQ-026 SHALL increment stall_cnt_o on each clock with stall_o=1, saturating at 16'hFFFF.
REQ-027 SHALL give outputs zero latency from the inputs and the entry state; state updates SHALL take one cycle.

Reset
REQ-028 SHALL, when rst_n=0 at a rising edge, clear all entry valid bits and zero stall_cnt_o.
REQ-029 SHALL give outputs after reset of fwd_a_o=0, fwd_b_o=0, stall_o=0 (no valid entries).
REQ-030 SHALL have reset override flush_i and issue_valid_i; a reset mid-stall SHALL drop the pending producer.

Structure
REQ-031 SHALL place the entry record typedef, the SEL_RF=0 constant and the ready encodings (READY_ALU=0, READY_LOAD=1) in the shared package pipe_pkg.
REQ-032 SHALL instantiate one sub-module, fwd_select, once per source: a priority match over the entries giving the select and a not-ready flag.

Verification
REQ-033 SHALL cover back-to-back ALU: issue rd=5 ready=0, next cycle src_a=5 -> fwd_a_o=1, stall_o=0.
REQ-034 SHALL cover load-use: issue rd=7 ready=1, next cycle src_b=7 -> stall_o=1 for one cycle; the next cycle fwd_b_o=2 and stall_cnt_o=1.
REQ-035 SHALL cover the youngest-wins rule: rd=3 issued twice consecutively, then src_a=3 -> fwd_a_o=1, not 2.
REQ-036 SHALL cover $zero and no-write: rd=0, or regwrite=0 with rd=4; src=0/4 -> fwd=0, stall=0.
REQ-037 SHALL cover flush: a load rd=9 in entry 0 with src_a=9 and flush_i=1 -> stall_o=0; the next cycle entry 0 is a bubble.
REQ-038 SHALL cover reset mid-stall: load-use stalled, rst_n=0 for one edge -> stall_o=0, stall_cnt_o=0, all fwd=0.
